// File: rtl/rand_arbiter_if.sv
// Handshake bundle between rand_arbiter, its requesters and the external LFSR.
// slave = arbiter side, master = requesters plus LFSR side.
interface rand_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [31:0]        rand_data;
  logic               rand_valid;
  logic               seed_wr;
  logic [31:0]        seed_in;
  logic               lfsr_load;
  logic [31:0]        lfsr_seed;
  logic               lfsr_en;
  logic [31:0]        lfsr_value;

  modport slave (
    input  req, seed_wr, seed_in, lfsr_value,
    output gnt, rand_data, rand_valid, lfsr_load, lfsr_seed, lfsr_en
  );

  modport master (
    output req, seed_wr, seed_in, lfsr_value,
    input  gnt, rand_data, rand_valid, lfsr_load, lfsr_seed, lfsr_en
  );
endinterface

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one external 32-bit LFSR; zero draws force a reseed and redraw.
// Optional RAND_DRAW_CNT_EN adds draw_count / zero_retry_count statistics outputs.
module rand_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned STEPS        = 1,
  parameter int unsigned SETTLE_CYC   = 2,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input  logic          clk,
  input  logic          clr_n,
  rand_arbiter_if.slave bus
`ifdef RAND_DRAW_CNT_EN
  ,
  output logic [15:0]   draw_count,
  output logic [7:0]    zero_retry_count
`endif
);

  localparam int unsigned  CW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]   STEP_LAST   = 4'(STEPS - 1);
  localparam logic [2:0]   SETTLE_LAST = 3'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LAST_REQ   = CW'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, DELIVER} state_t;

  state_t             state;
  logic [CW-1:0]      rr_ptr;
  logic [CW-1:0]      cur;
  logic [CW-1:0]      pick;
  logic [CW-1:0]      idx;
  logic               found;
  logic [3:0]         step_cnt;
  logic [2:0]         settle_cnt;
  logic [31:0]        seed_reg;
  logic [31:0]        rand_data_q;
  logic               need_seed;
  logic               pending;
  logic [NUM_REQ-1:0] gnt_q;
  logic               rand_valid_q;
  logic               lfsr_load_q;
  logic               lfsr_en_q;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = CW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur          <= '0;
      step_cnt     <= '0;
      settle_cnt   <= '0;
      seed_reg     <= SEED_DEFAULT;
      rand_data_q  <= '0;
      need_seed    <= 1'b1;
      pending      <= 1'b0;
      gnt_q        <= '0;
      rand_valid_q <= 1'b0;
      lfsr_load_q  <= 1'b0;
      lfsr_en_q    <= 1'b0;
`ifdef RAND_DRAW_CNT_EN
      draw_count       <= '0;
      zero_retry_count <= '0;
`endif
    end else begin
      lfsr_load_q  <= 1'b0;
      rand_valid_q <= 1'b0;
      gnt_q        <= '0;
      case (state)
        IDLE: begin
          if (need_seed) begin
            lfsr_load_q <= 1'b1;
            state       <= LOAD;
          end else if (|bus.req) begin
            cur       <= pick;
            pending   <= 1'b1;
            step_cnt  <= '0;
            lfsr_en_q <= 1'b1;
            state     <= STEP;
          end
        end
        LOAD: begin
          need_seed <= 1'b0;
          if (pending) begin
            step_cnt  <= '0;
            lfsr_en_q <= 1'b1;
            state     <= STEP;
          end else begin
            state <= IDLE;
          end
        end
        STEP: begin
          if (step_cnt == STEP_LAST) begin
            lfsr_en_q  <= 1'b0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            if (bus.lfsr_value != '0) begin
              rand_data_q  <= bus.lfsr_value;
              rand_valid_q <= 1'b1;
              gnt_q[cur]   <= 1'b1;
              state        <= DELIVER;
            end else begin
              // Reseed and redraw for the same requester; pending keeps LOAD on the retry path.
              need_seed   <= 1'b1;
              lfsr_load_q <= 1'b1;
              state       <= LOAD;
`ifdef RAND_DRAW_CNT_EN
              if (zero_retry_count != '1) zero_retry_count <= zero_retry_count + 1'b1;
`endif
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        DELIVER: begin
          rr_ptr  <= (cur == LAST_REQ) ? '0 : cur + 1'b1;
          pending <= 1'b0;
          state   <= IDLE;
`ifdef RAND_DRAW_CNT_EN
          if (draw_count != '1) draw_count <= draw_count + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
      // Placed last so a seed write always wins over the need_seed clear in LOAD.
      if (bus.seed_wr) begin
        seed_reg  <= (bus.seed_in == '0) ? SEED_DEFAULT : bus.seed_in;
        need_seed <= 1'b1;
      end
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rand_data  = rand_data_q;
  assign bus.rand_valid = rand_valid_q;
  assign bus.lfsr_load  = lfsr_load_q;
  assign bus.lfsr_seed  = seed_reg;
  assign bus.lfsr_en    = lfsr_en_q;

endmodule
